// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the instruction sequencer.
//   - state_t       : sequencer FSM states
//   - kind_t        : instruction class latched at DECODE
//   - ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   - LAT_*         : FETCH1-to-next-FETCH1 cycle counts per class
//   - decode_kind() : resolves the decoder flags to a single class
package cpu_ctrl_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   localparam int LAT_ALU    = 5;
   localparam int LAT_BRANCH = 4;
   localparam int LAT_STORE  = 6;
   localparam int LAT_LOAD   = 7;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH1,
      S_FETCH2,
      S_DECODE,
      S_EXEC,
      S_MEM1,
      S_MEM2,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [1:0] {
      K_ALU,
      K_LOAD,
      K_STORE,
      K_BRANCH
   } kind_t;

   // Load wins over store so a word flagged as both behaves as a load.
   function automatic kind_t decode_kind(input logic ld, input logic st, input logic br);
      if (ld) return K_LOAD;
      if (st) return K_STORE;
      if (br) return K_BRANCH;
      return K_ALU;
   endfunction

endpackage

// File: rtl/instr_seq_pc_unit.sv
// pc_unit: program counter register for the instruction sequencer.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (pc -> 0)
//   inc           : advance pc by one (wraps at 2^ADDR_W-1 -> 0)
//   take_br       : load pc from br_target (has priority over inc)
//   br_target     : branch destination
//   pc            : current program counter
module pc_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              take_br,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;

   // Natural modulo-2^ADDR_W addition gives the wrap to zero.
   always_comb begin
      pc_d = pc_q;
      if (take_br) begin
         pc_d = br_target;
      end else if (inc) begin
         pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_seq.sv
// instr_seq: multi-cycle instruction sequencer (fetch/decode/execute/memory/writeback).
// Optional build macro: SINGLE_STEP_EN adds a 'step' input; leaving IDLE then
// needs run=1 and step=1 together, and every instruction returns to IDLE.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   run                   : enable, sampled at instruction boundaries
//   step                  : single-step strobe (SINGLE_STEP_EN builds only)
//   instr_in              : ROM instruction word
//   dec_load/store/branch/halt : decoder flags for the current ir
//   zero_flag             : ALU zero flag (branch condition)
//   br_target, mem_addr   : branch destination, effective RAM address
//   addr_rom, clk_rom, ir : program counter, ROM strobe, latched instruction
//   addr_ram, clk_ram, wren : RAM address, RAM strobe, RAM write enable
//   reg_wr, load_sel      : register write strobe, write source is RAM data
//   halted, retired       : HALT reached, retired-instruction count
module instr_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [DATA_W-1:0] instr_in,
   input  logic              dec_load,
   input  logic              dec_store,
   input  logic              dec_branch,
   input  logic              dec_halt,
   input  logic              zero_flag,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] addr_rom,
   output logic              clk_rom,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] addr_ram,
   output logic              clk_ram,
   output logic              wren,
   output logic              reg_wr,
   output logic              load_sel,
   output logic              halted,
   output logic [15:0]       retired
);

   state_t            state_d,    state_q;
   kind_t             kind_d,     kind_q;
   logic [DATA_W-1:0] ir_d,       ir_q;
   logic [ADDR_W-1:0] addr_ram_d, addr_ram_q;
   logic [15:0]       retired_d,  retired_q;

   logic pc_inc;
   logic pc_br;
   logic done;
   logic start_ok;
   logic cont_ok;

`ifdef SINGLE_STEP_EN
   assign start_ok = run & step;
   assign cont_ok  = 1'b0;
`else
   assign start_ok = run;
   assign cont_ok  = run;
`endif

   pc_unit #(
      .ADDR_W   (ADDR_W)
   ) u_pc (
      .clk      (clk),
      .reset    (reset),
      .inc      (pc_inc),
      .take_br  (pc_br),
      .br_target(br_target),
      .pc       (addr_rom)
   );

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      ir_d       = ir_q;
      addr_ram_d = addr_ram_q;
      retired_d  = retired_q;
      pc_inc     = 1'b0;
      pc_br      = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE:   if (start_ok) state_d = S_FETCH1;
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: begin
            ir_d    = instr_in;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (dec_halt) begin
               state_d = S_HALT;
            end else begin
               kind_d  = decode_kind(dec_load, dec_store, dec_branch);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (kind_q)
               K_LOAD, K_STORE: begin
                  addr_ram_d = mem_addr;
                  state_d    = S_MEM1;
               end
               K_BRANCH: begin
                  pc_br  = zero_flag;
                  pc_inc = ~zero_flag;
                  done   = 1'b1;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM1: state_d = S_MEM2;
         S_MEM2: begin
            if (kind_q == K_LOAD) begin
               state_d = S_WB;
            end else begin
               pc_inc = 1'b1;
               done   = 1'b1;
            end
         end
         S_WB: begin
            pc_inc = 1'b1;
            done   = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      // Instruction boundary: count it, then either fetch the next one or
      // park in IDLE when run has dropped (pc keeps its new value).
      if (done) begin
         retired_d = retired_q + 16'd1;
         state_d   = cont_ok ? S_FETCH1 : S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         kind_q     <= K_ALU;
         ir_q       <= '0;
         addr_ram_q <= '0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         ir_q       <= ir_d;
         addr_ram_q <= addr_ram_d;
         retired_q  <= retired_d;
      end
   end

   // Strobes decode straight from the registered state, so reset clears
   // them in the very next cycle.
   assign clk_rom  = (state_q == S_FETCH1);
   assign clk_ram  = (state_q == S_MEM1);
   assign wren     = clk_ram && (kind_q == K_STORE);
   assign reg_wr   = (state_q == S_WB);
   assign load_sel = reg_wr && (kind_q == K_LOAD);
   assign halted   = (state_q == S_HALT);
   assign ir       = ir_q;
   assign addr_ram = addr_ram_q;
   assign retired  = retired_q;

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, ROM/RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction/data width.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  enable; sampled at instruction boundaries.
- instr_in  in  DATA_W  instruction word from ROM.
- dec_load, dec_store, dec_branch, dec_halt  in  1 each  decoder flags for current ir.
- zero_flag  in  1  ALU zero flag.
- br_target  in  ADDR_W  branch destination.
- mem_addr  in  ADDR_W  effective RAM address.
- addr_rom  out  ADDR_W  program counter.
- clk_rom  out  1  ROM clock strobe.
- ir  out  DATA_W  latched instruction.
- addr_ram  out  ADDR_W  RAM address.
- clk_ram  out  1  RAM clock strobe.
- wren  out  1  RAM write enable.
- reg_wr  out  1  register-file write strobe.
- load_sel  out  1  register write source is RAM data.
- halted  out  1  HALT state reached.
- retired  out  16  retired-instruction count.

Function
REQ-004 SHALL implement states IDLE, FETCH1, FETCH2, DECODE, EXEC, MEM1, MEM2, WB, HALT.
REQ-005 IDLE: -> FETCH1 when run=1, else stay.
REQ-006 FETCH1: clk_rom=1 exactly one cycle; -> FETCH2.
REQ-007 FETCH2: ir <= instr_in at cycle end; -> DECODE.
REQ-008 DECODE: priority halt > load > store > branch > ALU; dec_halt=1 -> HALT, else -> EXEC.
REQ-009 EXEC: load/store -> MEM1, addr_ram <= mem_addr; branch -> pc <= br_target if zero_flag=1 else pc+1, -> FETCH1; ALU -> WB.
REQ-010 MEM1: clk_ram=1 one cycle; wren=1 this cycle only, stores only.
REQ-011 MEM2: clk_ram=0; load -> WB; store -> pc <= pc+1, -> FETCH1.
REQ-012 WB: reg_wr=1 one cycle; load_sel=1 for loads only; pc <= pc+1; -> FETCH1.
REQ-013 Latency in cycles FETCH1..next FETCH1: ALU 5, branch 4, store 6, load 7.
REQ-014 Branch and store instructions SHALL not assert reg_wr.
REQ-015 On each transition into FETCH1 from EXEC, MEM2 or WB: if run=0 -> IDLE instead; pc preserved.
REQ-016 pc SHALL wrap 2^ADDR_W-1 -> 0; branch to the same address is legal.
REQ-017 retired SHALL increment once per completed non-halt instruction, wrapping at 65535.
REQ-018 HALT: all strobes 0, halted=1, exit only via reset.
REQ-019 If dec_load and dec_store are both 1, the instruction SHALL execute as a load.

Reset
REQ-020 reset=1 at a rising edge SHALL force IDLE, pc=0, ir=0, addr_ram=0, retired=0, all strobes and halted 0, from any state, mid-access included.
REQ-021 No RAM write SHALL occur in the cycle after reset is sampled.

Configuration
REQ-022 With SINGLE_STEP_EN defined: add input step (1 bit); IDLE -> FETCH1 requires run=1 and step=1 in the same cycle; every instruction returns to IDLE.
REQ-023 Without SINGLE_STEP_EN: no step port; behaviour per REQ-005/REQ-015.

Structure
REQ-024 Package cpu_ctrl_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and latency constants.
REQ-025 Sub-module pc_unit (pc register, increment, branch mux, wrap) is natural; FSM stays in instr_seq.

Verification
REQ-026 Reset, run=1, ALU instr at pc 0 -> clk_rom high cycle 1, reg_wr high cycle 5, addr_rom=1 cycle 6.
REQ-027 Store, mem_addr=0x2A -> addr_ram=0x2A, clk_ram=1, wren=1 in one cycle only; no reg_wr; next fetch at pc+1.
REQ-028 Load -> clk_ram pulse, then reg_wr=1 with load_sel=1 two cycles later; 7-cycle instruction.
REQ-029 Branch at pc 0xFF: zero_flag=1, br_target=0x10 -> pc=0x10; zero_flag=0 -> pc=0x00 (wrap).
REQ-030 dec_halt=1 -> halted=1, strobes 0 for 20 cycles despite run=1; reset -> IDLE, retired=0.
REQ-031 reset asserted during MEM1 of a store -> next cycle IDLE, wren=0, clk_ram=0.
